pipe_hazard_ctrl: RTL and testbench

Parametrised hazard, forwarding and flush controller for the ARM pipeline. It replaces the fixed two-stage hazard detector and the tied-off flush/freeze nets.
- Tracks in-flight register writers in a scoreboard shift pipeline of STAGES entries: entry 0 = EXE, then MEM, WB, ...
- Produces stall, flush and per-operand forwarding selects.
- Sequences multi-cycle branch flushes.
- Honours an external freeze, e.g. a memory wait.

---
 rtl/arm_pipe_pkg.sv | 20 ++
 rtl/hazard_match.sv | 19 +
 rtl/pipe_hazard_ctrl.sv | 144 ++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arm_pipe_pkg.sv
// Shared types for the ARM pipeline hazard/forwarding controller.
// Scoreboard destinations are held at SB_DEST_W bits so one struct serves any REG_ADDR_W up to 8.
package arm_pipe_pkg;

  localparam int SB_DEST_W   = 8;
  localparam int FWD_SEL_RF  = 0;
  localparam int FWD_SEL_EXE = 1;

  typedef struct packed {
    logic                 valid;
    logic                 mem_r_en;
    logic [SB_DEST_W-1:0] dest;
  } sb_entry_t;

  typedef enum logic {
    FL_IDLE     = 1'b0,
    FL_FLUSHING = 1'b1
  } flush_state_t;

endpackage

// File: rtl/hazard_match.sv
// Compares one in-flight scoreboard entry against the two source operands of the ID instruction.
module hazard_match
  import arm_pipe_pkg::*;
(
  input  sb_entry_t            entry,
  input  logic [SB_DEST_W-1:0] src1,
  input  logic                 src1_used,
  input  logic [SB_DEST_W-1:0] src2,
  input  logic                 two_src,
  output logic                 m1,
  output logic                 m2,
  output logic                 is_load
);

  assign m1      = entry.valid & src1_used & (entry.dest == src1);
  assign m2      = entry.valid & two_src   & (entry.dest == src2);
  assign is_load = entry.valid & entry.mem_r_en;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard, forwarding and branch-flush controller: tracks in-flight writers over STAGES downstream
// stages and derives stall, flush and per-operand forwarding selects for the ID instruction.
module pipe_hazard_ctrl
  import arm_pipe_pkg::*;
#(
  parameter int REG_ADDR_W = 4,
  parameter int STAGES     = 3,
  parameter int FWD_EN     = 1,
  parameter int BR_PENALTY = 2,
  parameter int SEL_W      = $clog2(STAGES + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  issue_valid,
  input  logic                  issue_wb_en,
  input  logic                  issue_mem_r_en,
  input  logic [REG_ADDR_W-1:0] issue_dest,
  input  logic [REG_ADDR_W-1:0] src1,
  input  logic                  src1_used,
  input  logic [REG_ADDR_W-1:0] src2,
  input  logic                  two_src,
  input  logic                  branch_taken,
  input  logic                  ext_freeze,
  output logic                  stall,
  output logic                  flush,
  output logic [SEL_W-1:0]      fwd_sel_a,
  output logic [SEL_W-1:0]      fwd_sel_b,
  output logic [31:0]           stall_cnt
);

  localparam int CNT_W = $clog2(BR_PENALTY + 1);

  logic [STAGES-1:0]    sb_vld;
  logic [STAGES-1:0]    sb_load;
  logic [SB_DEST_W-1:0] sb_dest [STAGES];
  sb_entry_t            entry   [STAGES];

  logic [STAGES-1:0]    m1;
  logic [STAGES-1:0]    m2;
  logic [STAGES-1:0]    is_load;

  logic [SB_DEST_W-1:0] src1_ext;
  logic [SB_DEST_W-1:0] src2_ext;

  flush_state_t         fl_state;
  logic [CNT_W-1:0]     fl_cnt;
  logic                 out_en;

  logic                 stall_raw;
  logic                 flush_i;
  logic                 stall_i;
  logic [SEL_W-1:0]     sel_a;
  logic [SEL_W-1:0]     sel_b;

  assign src1_ext = SB_DEST_W'(src1);
  assign src2_ext = SB_DEST_W'(src2);

  for (genvar g = 0; g < STAGES; g++) begin : g_match
    assign entry[g] = '{valid: sb_vld[g], mem_r_en: sb_load[g], dest: sb_dest[g]};

    hazard_match u_match (
      .entry     (entry[g]),
      .src1      (src1_ext),
      .src1_used (src1_used),
      .src2      (src2_ext),
      .two_src   (two_src),
      .m1        (m1[g]),
      .m2        (m2[g]),
      .is_load   (is_load[g])
    );
  end

  // Hazard decision: load-use only when forwarding, otherwise any RAW short of the last stage
  always_comb begin
    stall_raw = 1'b0;
    if (FWD_EN != 0) begin
      stall_raw = (m1[0] | m2[0]) & is_load[0];
    end else begin
      for (int i = 0; i < STAGES - 1; i++) begin
        stall_raw = stall_raw | m1[i] | m2[i];
      end
    end
    stall_raw = stall_raw & issue_valid;
  end

  // Scan oldest to youngest so the youngest non-load-in-EXE writer overrides
  always_comb begin
    sel_a = SEL_W'(FWD_SEL_RF);
    sel_b = SEL_W'(FWD_SEL_RF);
    if (FWD_EN != 0) begin
      for (int i = STAGES - 1; i >= 0; i--) begin
        if (m1[i] && !(i == 0 && is_load[i])) sel_a = SEL_W'(i + FWD_SEL_EXE);
        if (m2[i] && !(i == 0 && is_load[i])) sel_b = SEL_W'(i + FWD_SEL_EXE);
      end
    end
  end

  // out_en masks all outputs during reset and the first cycle after it
  assign flush_i   = out_en & ((fl_state == FL_FLUSHING) | branch_taken);
  assign stall_i   = out_en & stall_raw & ~flush_i;
  assign flush     = flush_i;
  assign stall     = stall_i;
  assign fwd_sel_a = out_en ? sel_a : '0;
  assign fwd_sel_b = out_en ? sel_b : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) out_en <= 1'b0;
    else     out_en <= 1'b1;
  end

  // Control state: entry valids, flush sequencer and stall counter, all held under freeze
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sb_vld    <= '0;
      fl_state  <= FL_IDLE;
      fl_cnt    <= '0;
      stall_cnt <= '0;
    end else if (!ext_freeze) begin
      sb_vld <= {sb_vld[STAGES-2:0], issue_valid & issue_wb_en & ~stall_i & ~flush_i};

      if (out_en && branch_taken) begin
        fl_state <= FL_FLUSHING;
        fl_cnt   <= CNT_W'(BR_PENALTY);
      end else if (fl_state == FL_FLUSHING) begin
        fl_cnt <= fl_cnt - 1'b1;
        if (fl_cnt <= CNT_W'(1)) fl_state <= FL_IDLE;
      end

      if (stall_i && (stall_cnt != 32'hFFFF_FFFF)) stall_cnt <= stall_cnt + 32'd1;
    end
  end

  // Entry payload; only meaningful when the matching valid bit is set
  always_ff @(posedge clk) begin
    if (!ext_freeze) begin
      sb_load    <= {sb_load[STAGES-2:0], issue_mem_r_en};
      sb_dest[0] <= SB_DEST_W'(issue_dest);
      for (int i = 1; i < STAGES; i++) begin
        sb_dest[i] <= sb_dest[i-1];
      end
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: a forwarding instance and a no-forward instance share stimulus.
module tb_pipe_hazard_ctrl;

  localparam int S_STALL    = 0;
  localparam int S_FLUSH    = 1;
  localparam int S_FA       = 2;
  localparam int S_FB       = 3;
  localparam int S_CNT      = 4;
  localparam int S_NF_STALL = 5;
  localparam int S_NF_FA    = 6;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid, issue_wb_en, issue_mem_r_en;
  logic [3:0]  issue_dest, src1, src2;
  logic        src1_used, two_src, branch_taken, ext_freeze;

  logic        stall, flush;
  logic [1:0]  fwd_sel_a, fwd_sel_b;
  logic [31:0] stall_cnt;

  logic        nf_stall, nf_flush;
  logic [1:0]  nf_fwd_sel_a, nf_fwd_sel_b;
  logic [31:0] nf_stall_cnt;

  typedef struct {
    string       tag;
    int          sig;
    logic [31:0] val;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.REG_ADDR_W(4), .STAGES(3), .FWD_EN(1), .BR_PENALTY(2)) dut (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_wb_en(issue_wb_en),
    .issue_mem_r_en(issue_mem_r_en), .issue_dest(issue_dest), .src1(src1),
    .src1_used(src1_used), .src2(src2), .two_src(two_src), .branch_taken(branch_taken),
    .ext_freeze(ext_freeze), .stall(stall), .flush(flush), .fwd_sel_a(fwd_sel_a),
    .fwd_sel_b(fwd_sel_b), .stall_cnt(stall_cnt)
  );

  pipe_hazard_ctrl #(.REG_ADDR_W(4), .STAGES(3), .FWD_EN(0), .BR_PENALTY(2)) dut_nf (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_wb_en(issue_wb_en),
    .issue_mem_r_en(issue_mem_r_en), .issue_dest(issue_dest), .src1(src1),
    .src1_used(src1_used), .src2(src2), .two_src(two_src), .branch_taken(branch_taken),
    .ext_freeze(ext_freeze), .stall(nf_stall), .flush(nf_flush), .fwd_sel_a(nf_fwd_sel_a),
    .fwd_sel_b(nf_fwd_sel_b), .stall_cnt(nf_stall_cnt)
  );

  function automatic logic [31:0] observe(input int sig);
    case (sig)
      S_STALL:    return {31'd0, stall};
      S_FLUSH:    return {31'd0, flush};
      S_FA:       return {30'd0, fwd_sel_a};
      S_FB:       return {30'd0, fwd_sel_b};
      S_CNT:      return stall_cnt;
      S_NF_STALL: return {31'd0, nf_stall};
      S_NF_FA:    return {30'd0, nf_fwd_sel_a};
      default:    return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic push_exp(input string tag, input int sig, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.sig = sig;
    e.val = val;
    q.push_back(e);
  endtask

  task automatic check_all();
    exp_t        e;
    logic [31:0] obs;
    while (q.size() > 0) begin
      e   = q.pop_front();
      obs = observe(e.sig);
      checks++;
      assert (obs === e.val) else begin
        failures++;
        $error("FAIL %s observed=%0d expected=%0d", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    check_all();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    issue_valid = 0; issue_wb_en = 0; issue_mem_r_en = 0; issue_dest = 0;
    src1 = 0; src1_used = 0; src2 = 0; two_src = 0;
    branch_taken = 0; ext_freeze = 0;
  endtask

  task automatic drive(input logic v, input logic wb, input logic ld, input logic [3:0] d,
                       input logic [3:0] s1, input logic s1u, input logic [3:0] s2,
                       input logic s2u);
    issue_valid = v; issue_wb_en = wb; issue_mem_r_en = ld; issue_dest = d;
    src1 = s1; src1_used = s1u; src2 = s2; two_src = s2u;
  endtask

  task automatic drain();
    set_idle();
    for (int k = 0; k < 3; k++) step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    set_idle();
    rst = 1'b1;
    branch_taken = 1'b1;
    push_exp("rst_flush", S_FLUSH, 0);
    push_exp("rst_stall", S_STALL, 0);
    push_exp("rst_fa", S_FA, 0);
    push_exp("rst_fb", S_FB, 0);
    push_exp("rst_cnt", S_CNT, 0);
    step();
    rst = 1'b0;
    branch_taken = 1'b0;
    push_exp("post_rst_flush", S_FLUSH, 0);
    push_exp("post_rst_stall", S_STALL, 0);
    step();

    // Forwarding from EXE, MEM, WB, then register file; youngest writer wins
    drive(1, 1, 0, 3, 0, 0, 0, 0);
    push_exp("add_r3_stall", S_STALL, 0);
    step();
    drive(1, 0, 0, 0, 3, 1, 0, 0);
    push_exp("fwd_exe_a", S_FA, 1);
    push_exp("fwd_exe_stall", S_STALL, 0);
    step();
    push_exp("fwd_mem_a", S_FA, 2);
    step();
    push_exp("fwd_wb_a", S_FA, 3);
    step();
    push_exp("fwd_rf_a", S_FA, 0);
    step();
    drive(1, 1, 0, 4, 0, 0, 0, 0);
    step();
    step();
    drive(1, 0, 0, 0, 4, 1, 4, 1);
    push_exp("youngest_a", S_FA, 1);
    push_exp("youngest_b", S_FB, 1);
    step();
    drain();

    // Load-use: one bubble, then forward from MEM
    drive(1, 1, 1, 5, 0, 0, 0, 0);
    push_exp("ldr_r5_stall", S_STALL, 0);
    step();
    drive(1, 0, 0, 0, 0, 0, 5, 1);
    push_exp("lu_stall", S_STALL, 1);
    push_exp("lu_fb_blocked", S_FB, 0);
    push_exp("lu_cnt0", S_CNT, 0);
    step();
    push_exp("lu_release", S_STALL, 0);
    push_exp("lu_fb_mem", S_FB, 2);
    push_exp("lu_cnt1", S_CNT, 1);
    step();
    drain();

    // Freeze during a load-use stall holds everything
    drive(1, 1, 1, 6, 0, 0, 0, 0);
    step();
    drive(1, 0, 0, 0, 6, 1, 0, 0);
    ext_freeze = 1'b1;
    for (int k = 0; k < 4; k++) begin
      push_exp("frz_stall", S_STALL, 1);
      push_exp("frz_cnt", S_CNT, 1);
      push_exp("frz_fa", S_FA, 0);
      step();
    end
    ext_freeze = 1'b0;
    push_exp("unfrz_stall", S_STALL, 1);
    push_exp("unfrz_cnt", S_CNT, 1);
    step();
    push_exp("unfrz_release", S_STALL, 0);
    push_exp("unfrz_fa", S_FA, 2);
    push_exp("unfrz_cnt2", S_CNT, 2);
    step();
    drain();

    // Unused sources never match
    drive(1, 1, 1, 0, 0, 0, 0, 0);
    step();
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    push_exp("unused_stall", S_STALL, 0);
    push_exp("unused_fa", S_FA, 0);
    push_exp("unused_fb", S_FB, 0);
    step();
    drain();

    // No-forward instance stalls for two cycles on a RAW
    drive(1, 1, 0, 2, 0, 0, 0, 0);
    step();
    drive(1, 0, 0, 0, 2, 1, 0, 0);
    push_exp("nf_stall_c1", S_NF_STALL, 1);
    step();
    push_exp("nf_stall_c2", S_NF_STALL, 1);
    push_exp("nf_fa_zero", S_NF_FA, 0);
    step();
    push_exp("nf_stall_c3", S_NF_STALL, 0);
    step();
    drain();

    // Branch flush: pulse + two penalty cycles
    branch_taken = 1'b1;
    push_exp("br_flush0", S_FLUSH, 1);
    push_exp("br_stall0", S_STALL, 0);
    step();
    branch_taken = 1'b0;
    push_exp("br_flush1", S_FLUSH, 1);
    step();
    push_exp("br_flush2", S_FLUSH, 1);
    step();
    push_exp("br_flush_end", S_FLUSH, 0);
    step();

    // Branch coinciding with a load-use hazard: flush wins
    drive(1, 1, 1, 7, 0, 0, 0, 0);
    step();
    drive(1, 0, 0, 0, 7, 1, 0, 0);
    branch_taken = 1'b1;
    push_exp("brlu_flush", S_FLUSH, 1);
    push_exp("brlu_stall", S_STALL, 0);
    step();
    set_idle();
    push_exp("brlu_flush1", S_FLUSH, 1);
    step();
    push_exp("brlu_flush2", S_FLUSH, 1);
    step();
    push_exp("brlu_flush_end", S_FLUSH, 0);
    push_exp("brlu_cnt", S_CNT, 2);
    step();

    // Second branch in the second flush cycle reloads the counter
    branch_taken = 1'b1;
    push_exp("ext_flush0", S_FLUSH, 1);
    step();
    push_exp("ext_flush1", S_FLUSH, 1);
    step();
    branch_taken = 1'b0;
    push_exp("ext_flush2", S_FLUSH, 1);
    step();
    push_exp("ext_flush3", S_FLUSH, 1);
    step();
    push_exp("ext_flush_end", S_FLUSH, 0);
    step();

    // Asynchronous reset while flushing with three valid entries
    drive(1, 1, 0, 1, 0, 0, 0, 0);
    step();
    drive(1, 1, 0, 2, 0, 0, 0, 0);
    step();
    drive(1, 1, 0, 3, 0, 0, 0, 0);
    step();
    drive(1, 0, 0, 0, 3, 1, 0, 0);
    branch_taken = 1'b1;
    push_exp("pre_rst_flush", S_FLUSH, 1);
    push_exp("pre_rst_fa", S_FA, 1);
    push_exp("pre_rst_cnt", S_CNT, 2);
    @(negedge clk);
    check_all();
    #1;
    rst = 1'b1;
    #1;
    push_exp("async_rst_flush", S_FLUSH, 0);
    push_exp("async_rst_stall", S_STALL, 0);
    push_exp("async_rst_fa", S_FA, 0);
    push_exp("async_rst_cnt", S_CNT, 0);
    check_all();
    @(posedge clk);
    #1;
    rst = 1'b0;
    branch_taken = 1'b0;
    push_exp("rel_flush", S_FLUSH, 0);
    push_exp("rel_fa", S_FA, 0);
    step();
    push_exp("rel2_fa_cleared", S_FA, 0);
    push_exp("rel2_flush_cleared", S_FLUSH, 0);
    push_exp("rel2_stall", S_STALL, 0);
    push_exp("rel2_cnt", S_CNT, 0);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
